// File: rtl/mips_instr_encoder_pkg.sv
// Shared mnemonic ids, opcode/funct codes and load-FSM states for the MIPS instruction encoder.
// Opcode/funct values match the ones the control decoder consumes.
package mips_instr_encoder_pkg;

   typedef enum logic [4:0] {
      ID_ADD  = 5'd0,
      ID_SUB  = 5'd1,
      ID_AND  = 5'd2,
      ID_OR   = 5'd3,
      ID_XOR  = 5'd4,
      ID_SLT  = 5'd5,
      ID_JR   = 5'd6,
      ID_LW   = 5'd7,
      ID_SW   = 5'd8,
      ID_BEQ  = 5'd9,
      ID_BNE  = 5'd10,
      ID_ADDI = 5'd11,
      ID_ANDI = 5'd12,
      ID_ORI  = 5'd13,
      ID_XORI = 5'd14,
      ID_J    = 5'd15,
      ID_JAL  = 5'd16,
      ID_LUI  = 5'd17
   } mnem_t;

   localparam logic [5:0] MIPS_RTYPE = 6'h00;
   localparam logic [5:0] MIPS_J     = 6'h02;
   localparam logic [5:0] MIPS_JAL   = 6'h03;
   localparam logic [5:0] MIPS_BEQ   = 6'h04;
   localparam logic [5:0] MIPS_BNE   = 6'h05;
   localparam logic [5:0] MIPS_ADDI  = 6'h08;
   localparam logic [5:0] MIPS_ANDI  = 6'h0C;
   localparam logic [5:0] MIPS_ORI   = 6'h0D;
   localparam logic [5:0] MIPS_XORI  = 6'h0E;
   localparam logic [5:0] MIPS_LUI   = 6'h0F;
   localparam logic [5:0] MIPS_LW    = 6'h23;
   localparam logic [5:0] MIPS_SW    = 6'h2B;

   localparam logic [5:0] ADD_FUNCT_CODE = 6'h20;
   localparam logic [5:0] SUB_FUNCT_CODE = 6'h22;
   localparam logic [5:0] AND_FUNCT_CODE = 6'h24;
   localparam logic [5:0] OR_FUNCT_CODE  = 6'h25;
   localparam logic [5:0] XOR_FUNCT_CODE = 6'h26;
   localparam logic [5:0] SLT_FUNCT_CODE = 6'h2A;
   localparam logic [5:0] JR_FUNCT_CODE  = 6'h08;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_FULL = 2'd2
   } state_t;

   function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
      return {MIPS_RTYPE, rs, rt, rd, 5'd0, funct};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/mips_word_pack.sv
// Combinational packer: mnemonic id plus register/immediate/target fields -> 32-bit MIPS word.
// legal is low for ids outside the mnemonic table; word is then zero.
module mips_word_pack
   import mips_instr_encoder_pkg::*;
(
   input  logic [4:0]  id,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        legal
);

   always_comb begin
      word  = '0;
      legal = 1'b1;
      case (id)
         ID_ADD:  word = r_word(rs, rt, rd, ADD_FUNCT_CODE);
         ID_SUB:  word = r_word(rs, rt, rd, SUB_FUNCT_CODE);
         ID_AND:  word = r_word(rs, rt, rd, AND_FUNCT_CODE);
         ID_OR:   word = r_word(rs, rt, rd, OR_FUNCT_CODE);
         ID_XOR:  word = r_word(rs, rt, rd, XOR_FUNCT_CODE);
         ID_SLT:  word = r_word(rs, rt, rd, SLT_FUNCT_CODE);
         ID_JR:   word = r_word(rs, 5'd0, 5'd0, JR_FUNCT_CODE);
         ID_LW:   word = i_word(MIPS_LW, rs, rt, imm);
         ID_SW:   word = i_word(MIPS_SW, rs, rt, imm);
         ID_BEQ:  word = i_word(MIPS_BEQ, rs, rt, imm);
         ID_BNE:  word = i_word(MIPS_BNE, rs, rt, imm);
         ID_ADDI: word = i_word(MIPS_ADDI, rs, rt, imm);
         ID_ANDI: word = i_word(MIPS_ANDI, rs, rt, imm);
         ID_ORI:  word = i_word(MIPS_ORI, rs, rt, imm);
         ID_XORI: word = i_word(MIPS_XORI, rs, rt, imm);
         ID_J:    word = {MIPS_J, target};
         ID_JAL:  word = {MIPS_JAL, target};
         ID_LUI:  word = i_word(MIPS_LUI, 5'd0, rt, imm);
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_instr_encoder.sv
// Load-session controller: accepts mnemonic requests, packs them and writes them sequentially
// into instruction memory through a registered write port.
module mips_instr_encoder
   import mips_instr_encoder_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_id,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              done,
   output logic              err_illegal,
   output logic              err_sticky
);

   localparam logic [ADDR_W:0] PTR_MAX = (ADDR_W+1)'(DEPTH);

   state_t          state;
   logic [ADDR_W:0] ptr;
   logic [ADDR_W:0] base;
   logic [ADDR_W:0] next_ptr;
   logic [31:0]     word;
   logic            legal;
   logic            accept;

   mips_word_pack u_pack (
      .id     (in_id),
      .rs     (in_rs),
      .rt     (in_rt),
      .rd     (in_rd),
      .imm    (in_imm),
      .target (in_target),
      .word   (word),
      .legal  (legal)
   );

   assign in_ready = (state == S_LOAD);
   assign accept   = in_valid & in_ready;
   // A request accepted alongside start becomes the first word of the restarted session.
   assign base     = start ? '0 : ptr;
   assign next_ptr = base + 1'b1;
   assign count    = ptr;
   assign full     = (ptr == PTR_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         ptr         <= '0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         done        <= 1'b0;
         err_illegal <= 1'b0;
         err_sticky  <= 1'b0;
      end else begin
         imem_we     <= 1'b0;
         done        <= 1'b0;
         err_illegal <= 1'b0;

         if (start) begin
            ptr        <= '0;
            err_sticky <= 1'b0;
         end

         if (accept) begin
            if (legal) begin
               imem_we    <= 1'b1;
               imem_addr  <= base[ADDR_W-1:0];
               imem_wdata <= word;
               ptr        <= next_ptr;
            end else begin
               err_illegal <= 1'b1;
               err_sticky  <= 1'b1;
            end
         end

         case (state)
            S_IDLE: if (start) state <= S_LOAD;
            S_LOAD: begin
               if (start) begin
                  state <= S_LOAD;
               end else if (finish) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end else if (accept && legal && next_ptr == PTR_MAX) begin
                  state <= S_FULL;
               end
            end
            S_FULL: begin
               if (start) begin
                  state <= S_LOAD;
               end else if (finish) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: per-cycle comparison against a session/word model,
// plus literal checks on the logged imem writes.
module tb_mips_instr_encoder;

   localparam int ADDR_W = 6;
   localparam int DEPTH  = 4;

   localparam int OPS[18] = '{0, 0, 0, 0, 0, 0, 0, 'h23, 'h2B, 'h04, 'h05,
                              'h08, 'h0C, 'h0D, 'h0E, 'h02, 'h03, 'h0F};
   localparam int FNS[7]  = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h2A, 'h08};

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              finish = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [4:0]        in_id = '0;
   logic [4:0]        in_rs = '0;
   logic [4:0]        in_rt = '0;
   logic [4:0]        in_rd = '0;
   logic [15:0]       in_imm = '0;
   logic [25:0]       in_target = '0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              done;
   logic              err_illegal;
   logic              err_sticky;

   int n_tests = 0;
   int n_fail  = 0;

   mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .finish      (finish),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_id       (in_id),
      .in_rs       (in_rs),
      .in_rt       (in_rt),
      .in_rd       (in_rd),
      .in_imm      (in_imm),
      .in_target   (in_target),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .count       (count),
      .full        (full),
      .done        (done),
      .err_illegal (err_illegal),
      .err_sticky  (err_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Field-level encoding straight from the instruction format table.
   function automatic logic [31:0] enc(input int id, input int rs, input int rt, input int rd,
                                       input int imm, input int tgt);
      longint w;
      if (id <= 5)
         w = longint'(rs) * 2**21 + longint'(rt) * 2**16 + longint'(rd) * 2**11 + FNS[id];
      else if (id == 6)
         w = longint'(rs) * 2**21 + FNS[6];
      else if (id == 15 || id == 16)
         w = longint'(OPS[id]) * 2**26 + tgt;
      else if (id == 17)
         w = longint'(OPS[id]) * 2**26 + longint'(rt) * 2**16 + imm;
      else
         w = longint'(OPS[id]) * 2**26 + longint'(rs) * 2**21 + longint'(rt) * 2**16 + imm;
      return w[31:0];
   endfunction

   // Model: mode 0 = no session, 1 = session open, 2 = session full.
   int          mode = 0;
   int          m_ptr = 0;
   bit          m_sticky = 0;
   bit          e_we = 0, e_done = 0, e_ill = 0;
   int          e_addr = 0;
   logic [31:0] e_wdata = '0;
   bit          acc;

   always @(posedge clk) begin
      if (rst) begin
         mode = 0; m_ptr = 0; m_sticky = 0;
         e_we = 0; e_done = 0; e_ill = 0; e_addr = 0; e_wdata = '0;
      end else begin
         acc = in_valid && (mode == 1);
         e_we = 0; e_done = 0; e_ill = 0;
         if (start) begin
            m_ptr = 0;
            m_sticky = 0;
         end
         if (acc) begin
            if (int'(in_id) > 17) begin
               e_ill = 1;
               m_sticky = 1;
            end else begin
               e_we = 1;
               e_addr = m_ptr;
               e_wdata = enc(int'(in_id), int'(in_rs), int'(in_rt), int'(in_rd),
                             int'(in_imm), int'(in_target));
               m_ptr++;
            end
         end
         if (start) mode = 1;
         else if (finish && mode != 0) begin
            mode = 0;
            e_done = 1;
         end else if (mode == 1 && m_ptr == DEPTH) mode = 2;
      end
   end

   logic [31:0] log_data[$];
   int          log_addr[$];
   int          done_cnt = 0;

   always @(negedge clk) begin
      chk("in_ready",    32'(in_ready),    32'(mode == 1));
      chk("imem_we",     32'(imem_we),     32'(e_we));
      chk("imem_addr",   32'(imem_addr),   32'(e_addr));
      chk("imem_wdata",  imem_wdata,       e_wdata);
      chk("count",       32'(count),       32'(m_ptr));
      chk("full",        32'(full),        32'(m_ptr == DEPTH));
      chk("done",        32'(done),        32'(e_done));
      chk("err_illegal", 32'(err_illegal), 32'(e_ill));
      chk("err_sticky",  32'(err_sticky),  32'(m_sticky));
      if (imem_we === 1'b1) begin
         log_data.push_back(imem_wdata);
         log_addr.push_back(int'(imem_addr));
      end
      if (done === 1'b1) done_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   task automatic pulse_finish();
      finish = 1'b1; step(); finish = 1'b0;
   endtask

   task automatic send(input int id, input int rs, input int rt, input int rd,
                       input int imm, input int tgt);
      in_id = 5'(id); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
      in_imm = 16'(imm); in_target = 26'(tgt);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_log(input string name, input int idx, input int addr, input logic [31:0] data);
      if (idx < log_data.size()) begin
         chk({name, "_addr"}, 32'(log_addr[idx]), 32'(addr));
         chk({name, "_data"}, log_data[idx], data);
      end else begin
         chk({name, "_present"}, 32'(log_data.size()), 32'(idx + 1));
      end
   endtask

   int base_idx;

   initial begin
      chk("model_addi", enc(11, 1, 2, 0, 5, 0), 32'h20220005);
      chk("model_jr",   enc(6, 31, 0, 0, 0, 0), 32'h03E00008);
      chk("model_lui",  enc(17, 7, 4, 0, 'h1234, 0), 32'h3C041234);

      repeat (3) step();
      rst = 1'b0;
      settle();
      chk("reset_ready", 32'(in_ready), 32'd0);
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_wdata", imem_wdata, 32'd0);

      // Single ADDI
      pulse_start();
      base_idx = log_data.size();
      send(11, 1, 2, 0, 'h0005, 0);
      settle();
      chk_log("addi", base_idx, 0, 32'h20220005);
      chk("addi_count", 32'(count), 32'd1);
      pulse_finish();
      step();

      // ADD then JR back-to-back
      pulse_start();
      base_idx = log_data.size();
      send(0, 1, 2, 3, 0, 0);
      send(6, 31, 0, 0, 0, 0);
      settle();
      chk_log("add", base_idx, 0, 32'h00221820);
      chk_log("jr", base_idx + 1, 1, 32'h03E00008);
      pulse_finish();
      step();

      // J, JAL, LUI (rs ignored)
      pulse_start();
      base_idx = log_data.size();
      send(15, 0, 0, 0, 0, 'h0000010);
      send(16, 0, 0, 0, 0, 'h0000010);
      send(17, 7, 4, 0, 'h1234, 0);
      settle();
      chk_log("j", base_idx, 0, 32'h08000010);
      chk_log("jal", base_idx + 1, 1, 32'h0C000010);
      chk_log("lui", base_idx + 2, 2, 32'h3C041234);

      // Illegal id in the same session
      base_idx = log_data.size();
      send(31, 1, 2, 3, 0, 0);
      settle();
      chk("illegal_nowrite", 32'(log_data.size()), 32'(base_idx));
      chk("illegal_sticky", 32'(err_sticky), 32'd1);
      chk("illegal_count", 32'(count), 32'd3);

      // Restart in LOAD clears sticky; fill to DEPTH with 5 requests
      pulse_start();
      chk("restart_sticky", 32'(err_sticky), 32'd0);
      chk("restart_count", 32'(count), 32'd0);
      base_idx = log_data.size();
      for (int i = 0; i < 5; i++) send(11, 0, 1, 0, i + 1, 0);
      settle();
      chk("full_writes", 32'(log_data.size() - base_idx), 32'd4);
      for (int i = 0; i < 4; i++) chk_log("fill", base_idx + i, i, 32'h20010000 + 32'(i + 1));
      chk("full_flag", 32'(full), 32'd1);
      chk("full_ready", 32'(in_ready), 32'd0);
      chk("full_count", 32'(count), 32'd4);
      pulse_finish();
      settle();
      chk("done_pulses", 32'(done_cnt), 32'd3);
      chk("idle_ready", 32'(in_ready), 32'd0);

      // Reset coinciding with an accept drops the write
      pulse_start();
      base_idx = log_data.size();
      in_id = 5'd11; in_rs = 5'd1; in_rt = 5'd2; in_imm = 16'h0007;
      in_valid = 1'b1;
      rst = 1'b1;
      step();
      in_valid = 1'b0;
      rst = 1'b0;
      settle();
      chk("rst_nowrite", 32'(log_data.size()), 32'(base_idx));
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_flags", {28'd0, full, done, err_illegal, err_sticky}, 32'd0);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
